tag_matcher: RTL and testbench

TAG_MATCHER -- requirements
Module: tag_matcher

---
 rtl/tag_matcher_pkg.sv | 17 +
 rtl/tag_matcher_compare.sv | 25 ++
 rtl/tag_matcher.sv | 166 ++++++++++++++++
 tb/tb_tag_matcher.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tag_matcher_pkg.sv
// Shared widths and metadata layout for the tag matcher.
// The tag_matcher parameters take their defaults from here.
package tag_matcher_pkg;

  localparam int unsigned DEF_AXI_ADDR_WIDTH = 64;
  localparam int unsigned DEF_TID_WIDTH      = 10;
  localparam int unsigned DEF_INDEX_WIDTH    = 10;
  localparam int unsigned DEF_OFFSET_WIDTH   = 6;
  localparam int unsigned DEF_AXI_DATA_WIDTH = 512;
  localparam int unsigned DEF_TAG_WIDTH      = DEF_AXI_ADDR_WIDTH - DEF_INDEX_WIDTH - DEF_OFFSET_WIDTH;

  // Metadata layout in the low bits of the first R beat.
  localparam int unsigned META_VALID_BIT = 0;
  localparam int unsigned META_DIRTY_BIT = 1;
  localparam int unsigned META_TAG_LSB   = 2;

endpackage

// File: rtl/tag_matcher_compare.sv
// Combinational metadata decode and tag comparison (module tag_compare).
import tag_matcher_pkg::*;

module tag_compare #(
  parameter int unsigned TAG_WIDTH = DEF_TAG_WIDTH
) (
  input  logic [META_TAG_LSB+TAG_WIDTH-1:0] i_meta,
  input  logic [TAG_WIDTH-1:0]              i_addr_tag,
  output logic                              o_hit_c,
  output logic                              o_dirty_c
);

  logic                 w_valid;
  logic                 w_dirty;
  logic [TAG_WIDTH-1:0] w_tag;

  assign w_valid = i_meta[META_VALID_BIT];
  assign w_dirty = i_meta[META_DIRTY_BIT];
  assign w_tag   = i_meta[META_TAG_LSB +: TAG_WIDTH];

  // A dirty line only matters when it is about to be replaced.
  assign o_hit_c   = w_valid && (w_tag == i_addr_tag);
  assign o_dirty_c = w_valid && w_dirty && !o_hit_c;

endmodule

// File: rtl/tag_matcher.sv
// Pops one tag FIFO entry at a time, reads its metadata beat and reports hit/dirty.
// Optional hit/miss counters are built only when TAG_MATCHER_STATS_EN is defined.
module tag_matcher
  import tag_matcher_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = DEF_AXI_ADDR_WIDTH,
  parameter int unsigned TID_WIDTH    = DEF_TID_WIDTH,
  parameter int unsigned INDEX_WIDTH  = DEF_INDEX_WIDTH,
  parameter int unsigned OFFSET_WIDTH = DEF_OFFSET_WIDTH,
  parameter int unsigned DATA_WIDTH   = DEF_AXI_DATA_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tag_fifo_empty_i,
  output logic                          tag_fifo_rden_o,
  input  logic [ADDR_WIDTH+TID_WIDTH:0] tag_fifo_data_i,
  input  logic [DATA_WIDTH-1:0]         rdata_i,
  input  logic                          rlast_i,
  input  logic                          rvalid_i,
  output logic                          rready_o,
  output logic                          result_valid_o,
  input  logic                          result_ready_i,
  output logic                          result_hit_o,
  output logic                          result_dirty_o,
  output logic                          result_write_o,
  output logic [TID_WIDTH-1:0]          result_tid_o,
  output logic [ADDR_WIDTH-1:0]         result_addr_o,
  output logic [DATA_WIDTH-1:0]         result_data_o,
  output logic [31:0]                   hit_cnt_o,
  output logic [31:0]                   miss_cnt_o
);

  localparam int unsigned TAG_WIDTH  = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;
  localparam int unsigned TAG_LSB    = INDEX_WIDTH + OFFSET_WIDTH;
  localparam int unsigned META_WIDTH = META_TAG_LSB + TAG_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_POP    = 3'd1,
    S_LATCH  = 3'd2,
    S_WAIT_R = 3'd3,
    S_DRAIN  = 3'd4,
    S_CMP    = 3'd5,
    S_OUT    = 3'd6
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  w_beat;
  logic                  w_hit;
  logic                  w_dirty;

  logic                  r_rden;
  logic                  r_rready;
  logic                  r_valid;
  logic                  r_hit;
  logic                  r_dirty;
  logic                  r_write;
  logic [TID_WIDTH-1:0]  r_tid;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state decode; w_beat marks the first R beat being accepted.
  always_comb begin
    w_state_nxt = r_state;
    w_beat      = 1'b0;
    unique case (r_state)
      S_IDLE:   if (!tag_fifo_empty_i) w_state_nxt = S_POP;
      S_POP:    w_state_nxt = S_LATCH;
      S_LATCH:  w_state_nxt = S_WAIT_R;
      S_WAIT_R: begin
        if (rvalid_i) begin
          w_beat      = 1'b1;
          w_state_nxt = rlast_i ? S_CMP : S_DRAIN;
        end
      end
      S_DRAIN:  if (rvalid_i && rlast_i) w_state_nxt = S_CMP;
      S_CMP:    w_state_nxt = S_OUT;
      S_OUT:    if (result_ready_i) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  tag_compare #(
    .TAG_WIDTH (TAG_WIDTH)
  ) u_tag_compare (
    .i_meta     (r_data[META_WIDTH-1:0]),
    .i_addr_tag (r_addr[ADDR_WIDTH-1:TAG_LSB]),
    .o_hit_c    (w_hit),
    .o_dirty_c  (w_dirty)
  );

  // Strobes are registered from the next state so they line up with the state itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rden   <= 1'b0;
      r_rready <= 1'b0;
      r_valid  <= 1'b0;
      r_hit    <= 1'b0;
      r_dirty  <= 1'b0;
      r_write  <= 1'b0;
      r_tid    <= '0;
      r_addr   <= '0;
      r_data   <= '0;
    end else begin
      r_rden   <= (w_state_nxt == S_POP);
      r_rready <= (w_state_nxt == S_WAIT_R) || (w_state_nxt == S_DRAIN);
      r_valid  <= (w_state_nxt == S_OUT);
      if (r_state == S_LATCH) begin
        r_write <= tag_fifo_data_i[ADDR_WIDTH+TID_WIDTH];
        r_tid   <= tag_fifo_data_i[ADDR_WIDTH +: TID_WIDTH];
        r_addr  <= tag_fifo_data_i[ADDR_WIDTH-1:0];
      end
      if (w_beat) r_data <= rdata_i;
      if (r_state == S_CMP) begin
        r_hit   <= w_hit;
        r_dirty <= w_dirty;
      end
    end
  end

  assign tag_fifo_rden_o = r_rden;
  assign rready_o        = r_rready;
  assign result_valid_o  = r_valid;
  assign result_hit_o    = r_hit;
  assign result_dirty_o  = r_dirty;
  assign result_write_o  = r_write;
  assign result_tid_o    = r_tid;
  assign result_addr_o   = r_addr;
  assign result_data_o   = r_data;

`ifdef TAG_MATCHER_STATS_EN
  logic        w_done;
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;

  assign w_done = (r_state == S_OUT) && result_ready_i;

  // Saturating hit/miss counters, bumped on each result handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hit_cnt  <= 32'd0;
      r_miss_cnt <= 32'd0;
    end else if (w_done) begin
      if (r_hit) begin
        if (r_hit_cnt != 32'hFFFF_FFFF) r_hit_cnt <= r_hit_cnt + 32'd1;
      end else begin
        if (r_miss_cnt != 32'hFFFF_FFFF) r_miss_cnt <= r_miss_cnt + 32'd1;
      end
    end
  end

  assign hit_cnt_o  = r_hit_cnt;
  assign miss_cnt_o = r_miss_cnt;
`else
  assign hit_cnt_o  = 32'd0;
  assign miss_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_tag_matcher.sv
// Self-checking bench for tag_matcher: directed vector table, corner sequences and random traffic.
module tb_tag_matcher;

  localparam int unsigned ADDR_W = 64;
  localparam int unsigned TID_W  = 10;
  localparam int unsigned IDX_W  = 10;
  localparam int unsigned OFF_W  = 6;
  localparam int unsigned DATA_W = 512;
  localparam int unsigned TAG_W  = ADDR_W - IDX_W - OFF_W;

`ifdef TAG_MATCHER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct { logic write; logic [TID_W-1:0] tid; logic [ADDR_W-1:0] addr; } entry_t;
  typedef struct { logic [DATA_W-1:0] data; logic last; } beat_t;
  typedef struct {
    logic hit; logic dirty; logic write; logic [TID_W-1:0] tid;
    logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data;
  } res_t;
  typedef struct {
    logic write; logic [TID_W-1:0] tid; logic [ADDR_W-1:0] addr;
    logic [TAG_W-1:0] tag; logic v; logic d; int nb; logic eh; logic ed;
  } vec_t;

  logic                 clk;
  logic                 rst;
  logic                 tag_fifo_empty_i;
  logic                 tag_fifo_rden_o;
  logic [ADDR_W+TID_W:0] tag_fifo_data_i;
  logic [DATA_W-1:0]    rdata_i;
  logic                 rlast_i;
  logic                 rvalid_i;
  logic                 rready_o;
  logic                 result_valid_o;
  logic                 result_ready_i;
  logic                 result_hit_o;
  logic                 result_dirty_o;
  logic                 result_write_o;
  logic [TID_W-1:0]     result_tid_o;
  logic [ADDR_W-1:0]    result_addr_o;
  logic [DATA_W-1:0]    result_data_o;
  logic [31:0]          hit_cnt_o;
  logic [31:0]          miss_cnt_o;

  tag_matcher dut (
    .clk              (clk),
    .rst              (rst),
    .tag_fifo_empty_i (tag_fifo_empty_i),
    .tag_fifo_rden_o  (tag_fifo_rden_o),
    .tag_fifo_data_i  (tag_fifo_data_i),
    .rdata_i          (rdata_i),
    .rlast_i          (rlast_i),
    .rvalid_i         (rvalid_i),
    .rready_o         (rready_o),
    .result_valid_o   (result_valid_o),
    .result_ready_i   (result_ready_i),
    .result_hit_o     (result_hit_o),
    .result_dirty_o   (result_dirty_o),
    .result_write_o   (result_write_o),
    .result_tid_o     (result_tid_o),
    .result_addr_o    (result_addr_o),
    .result_data_o    (result_data_o),
    .hit_cnt_o        (hit_cnt_o),
    .miss_cnt_o       (miss_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  entry_t fifo_q[$];
  beat_t  beat_q[$];
  res_t   exp_q[$];
  int     n_checks = 0;
  int     n_pass = 0;
  int     n_pops = 0;
  int     n_acc = 0;
  int     exp_acc = 0;
  int     n_results = 0;
  int     exp_hits = 0;
  int     exp_misses = 0;
  int     cyc = 0;
  int     last_acc_cyc = 0;
  logic   prev_valid = 1'b0;
  int     ready_mode = 1;
  bit     gap_en = 1'b0;

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [DATA_W-1:0] rand512();
    logic [DATA_W-1:0] v;
    for (int i = 0; i < DATA_W / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  // Reference rule: hit when the line is valid and its stored tag equals the address tag.
  function automatic void ref_model(input entry_t e, input logic [DATA_W-1:0] d,
                                    output logic hit, output logic dirty);
    longint unsigned line_tag;
    longint unsigned stored;
    line_tag = e.addr / (64'd1 << (IDX_W + OFF_W));
    stored   = (d[63:0] >> 2) & ((64'd1 << TAG_W) - 64'd1);
    hit      = d[0] && (stored == line_tag);
    dirty    = d[0] && d[1] && !hit;
  endfunction

  task automatic drive_r();
    if (beat_q.size() > 0 && (!gap_en || $urandom_range(0, 2) != 0)) begin
      rvalid_i = 1'b1;
      rdata_i  = beat_q[0].data;
      rlast_i  = beat_q[0].last;
    end else begin
      rvalid_i = 1'b0;
      rlast_i  = 1'b0;
    end
  endtask

  // One clock: checks visible outputs, advances FIFO / R / result models from what the edge accepted.
  task automatic tick();
    logic   was_rst;
    logic   pop;
    logic   beat;
    logic   hs;
    entry_t e;
    beat_t  b;
    res_t   r;
    was_rst = rst;
    pop     = tag_fifo_rden_o && !was_rst;
    beat    = rready_o && rvalid_i && !was_rst;
    hs      = result_valid_o && result_ready_i && !was_rst;
    if (!was_rst && result_valid_o) begin
      if (exp_q.size() == 0) chk("spurious_result", DATA_W'(result_valid_o), DATA_W'(0));
      else begin
        chk("hit",   DATA_W'(result_hit_o),   DATA_W'(exp_q[0].hit));
        chk("dirty", DATA_W'(result_dirty_o), DATA_W'(exp_q[0].dirty));
        chk("write", DATA_W'(result_write_o), DATA_W'(exp_q[0].write));
        chk("tid",   DATA_W'(result_tid_o),   DATA_W'(exp_q[0].tid));
        chk("addr",  DATA_W'(result_addr_o),  DATA_W'(exp_q[0].addr));
        chk("data",  result_data_o,           exp_q[0].data);
      end
    end
    if (pop) chk("rden_while_empty", DATA_W'(tag_fifo_empty_i), DATA_W'(0));
    @(posedge clk);
    #1;
    cyc++;
    if (pop && fifo_q.size() > 0) begin
      e = fifo_q.pop_front();
      tag_fifo_data_i = {e.write, e.tid, e.addr};
      n_pops++;
    end
    if (beat && beat_q.size() > 0) begin
      b = beat_q.pop_front();
      n_acc++;
      if (b.last) last_acc_cyc = cyc - 1;
    end
    if (hs && exp_q.size() > 0) begin
      r = exp_q.pop_front();
      n_results++;
      if (r.hit) exp_hits++;
      else       exp_misses++;
    end
    tag_fifo_empty_i = (fifo_q.size() == 0);
    if (beat || !rvalid_i) drive_r();
    case (ready_mode)
      0:       result_ready_i = 1'b0;
      1:       result_ready_i = 1'b1;
      default: result_ready_i = 1'($urandom_range(0, 1));
    endcase
    chk("hit_cnt",  DATA_W'(hit_cnt_o),  DATA_W'(STATS ? exp_hits : 0));
    chk("miss_cnt", DATA_W'(miss_cnt_o), DATA_W'(STATS ? exp_misses : 0));
    if (result_valid_o && !prev_valid) chk("latency", DATA_W'(cyc - last_acc_cyc), DATA_W'(2));
    prev_valid = result_valid_o;
  endtask

  task automatic push_txn(input entry_t e, input logic [DATA_W-1:0] d0, input int nb,
                          input logic eh, input logic ed);
    fifo_q.push_back(e);
    beat_q.push_back('{d0, nb == 1});
    for (int i = 1; i < nb; i++) beat_q.push_back('{rand512(), i == nb - 1});
    exp_q.push_back('{eh, ed, e.write, e.tid, e.addr, d0});
    exp_acc += nb;
  endtask

  task automatic wait_results(input int target, input int budget);
    for (int k = 0; k < budget && n_results < target; k++) tick();
    chk("result_count", DATA_W'(n_results), DATA_W'(target));
  endtask

  task automatic check_zero(input string name);
    chk({name, "_rden"},   DATA_W'(tag_fifo_rden_o), DATA_W'(0));
    chk({name, "_rready"}, DATA_W'(rready_o),        DATA_W'(0));
    chk({name, "_valid"},  DATA_W'(result_valid_o),  DATA_W'(0));
    chk({name, "_hit"},    DATA_W'(result_hit_o),    DATA_W'(0));
    chk({name, "_dirty"},  DATA_W'(result_dirty_o),  DATA_W'(0));
    chk({name, "_write"},  DATA_W'(result_write_o),  DATA_W'(0));
    chk({name, "_tid"},    DATA_W'(result_tid_o),    DATA_W'(0));
    chk({name, "_addr"},   DATA_W'(result_addr_o),   DATA_W'(0));
    chk({name, "_data"},   result_data_o,            DATA_W'(0));
    chk({name, "_hcnt"},   DATA_W'(hit_cnt_o),       DATA_W'(0));
    chk({name, "_mcnt"},   DATA_W'(miss_cnt_o),      DATA_W'(0));
  endtask

  function automatic logic [DATA_W-1:0] meta_beat(input logic [TAG_W-1:0] tag, input logic v, input logic d);
    logic [DATA_W-1:0] x;
    x = rand512();
    x[TAG_W+1:0] = {tag, d, v};
    return x;
  endfunction

  vec_t vecs[6];

  initial begin
    entry_t            e;
    logic [DATA_W-1:0] d0;
    logic              eh;
    logic              ed;
    int                target;
    int                acc0;
    int                pops0;

    vecs[0] = '{1'b0, 10'd5,   64'h0000_1234_5678_0040, 48'h0000_1234_5678, 1'b1, 1'b0, 1, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 10'd5,   64'h0000_1234_5678_0040, 48'h0000_0000_0001, 1'b1, 1'b1, 1, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 10'h3FF, 64'hFFFF_FFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF, 1'b1, 1'b1, 4, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 10'd1,   64'h0000_1234_5678_0040, 48'h0000_1234_5678, 1'b0, 1'b1, 2, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 10'h155, 64'hABCD_0000_0000_FFFF, 48'hABCD_0000_0001, 1'b1, 1'b0, 3, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 10'h2AA, 64'h0000_0000_0001_FFFF, 48'h0000_0000_0001, 1'b1, 1'b0, 1, 1'b1, 1'b0};

    rst = 1'b1;
    tag_fifo_empty_i = 1'b1;
    tag_fifo_data_i = '0;
    rdata_i = '0;
    rlast_i = 1'b0;
    rvalid_i = 1'b0;
    result_ready_i = 1'b0;
    repeat (3) tick();
    check_zero("reset");
    rst = 1'b0;

    // Empty FIFO: nothing may be popped or requested.
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("empty_rden",   DATA_W'(tag_fifo_rden_o), DATA_W'(0));
      chk("empty_rready", DATA_W'(rready_o),        DATA_W'(0));
      chk("empty_valid",  DATA_W'(result_valid_o),  DATA_W'(0));
    end

    // Directed vector table.
    ready_mode = 1;
    for (int i = 0; i < 6; i++) begin
      e = '{vecs[i].write, vecs[i].tid, vecs[i].addr};
      d0 = meta_beat(vecs[i].tag, vecs[i].v, vecs[i].d);
      acc0 = n_acc;
      target = n_results + 1;
      push_txn(e, d0, vecs[i].nb, vecs[i].eh, vecs[i].ed);
      wait_results(target, 100);
      chk("vec_beats", DATA_W'(n_acc - acc0), DATA_W'(vecs[i].nb));
      repeat (2) tick();
    end

    // Result backpressure with a second entry waiting.
    ready_mode = 0;
    result_ready_i = 1'b0;
    target = n_results + 2;
    for (int i = 0; i < 2; i++) begin
      e = '{vecs[i].write, vecs[i].tid, vecs[i].addr};
      push_txn(e, meta_beat(vecs[i].tag, vecs[i].v, vecs[i].d), 1, vecs[i].eh, vecs[i].ed);
    end
    for (int k = 0; k < 100 && !result_valid_o; k++) tick();
    chk("bp_valid", DATA_W'(result_valid_o), DATA_W'(1));
    pops0 = n_pops;
    acc0 = n_acc;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("bp_rden",   DATA_W'(tag_fifo_rden_o), DATA_W'(0));
      chk("bp_rready", DATA_W'(rready_o),        DATA_W'(0));
      chk("bp_valid",  DATA_W'(result_valid_o),  DATA_W'(1));
    end
    chk("bp_pops", DATA_W'(n_pops), DATA_W'(pops0));
    chk("bp_beats", DATA_W'(n_acc), DATA_W'(acc0));
    ready_mode = 1;
    wait_results(target, 100);

    // Reset while draining a response; the entry is abandoned.
    e = '{vecs[0].write, vecs[0].tid, vecs[0].addr};
    fifo_q.push_back(e);
    beat_q.push_back('{meta_beat(vecs[0].tag, 1'b1, 1'b0), 1'b0});
    exp_acc++;
    acc0 = n_acc;
    for (int k = 0; k < 50 && n_acc == acc0; k++) tick();
    chk("drain_beat", DATA_W'(n_acc), DATA_W'(acc0 + 1));
    repeat (2) tick();
    chk("drain_rready", DATA_W'(rready_o), DATA_W'(1));
    rst = 1'b1;
    exp_hits = 0;
    exp_misses = 0;
    tick();
    check_zero("rst_drain");
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("post_rst_valid", DATA_W'(result_valid_o), DATA_W'(0));
    end
    target = n_results + 1;
    push_txn(e, meta_beat(vecs[0].tag, 1'b1, 1'b0), 2, 1'b1, 1'b0);
    wait_results(target, 100);

    // Random traffic against the reference rule.
    ready_mode = 2;
    gap_en = 1'b1;
    for (int bt = 0; bt < 12; bt++) begin
      target = n_results;
      for (int j = 0; j < int'($urandom_range(1, 3)); j++) begin
        e.write = 1'($urandom_range(0, 1));
        e.tid   = TID_W'($urandom_range(0, 1023));
        e.addr  = {$urandom(), $urandom()};
        d0 = meta_beat($urandom_range(0, 1) != 0 ? e.addr[ADDR_W-1:IDX_W+OFF_W] : TAG_W'({$urandom(), $urandom()}),
                       1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
        ref_model(e, d0, eh, ed);
        push_txn(e, d0, int'($urandom_range(1, 4)), eh, ed);
        target++;
      end
      wait_results(target, 400);
    end
    ready_mode = 1;
    repeat (4) tick();
    chk("beat_total", DATA_W'(n_acc), DATA_W'(exp_acc));
    chk("beat_q_empty", DATA_W'(beat_q.size()), DATA_W'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
